mandelbrot_frame_engine: RTL and testbench
==========================================

Name: mandelbrot_frame_engine

Overview:
Parametrised next-generation fractal pixel engine. Scans a WIDTH x HEIGHT frame in raster order and iterates z <- z^2 + c once per clock on an internal signed fixed-point datapath. Supports Mandelbrot and Julia modes, independent per-axis signed step sizes, and full-width iteration counts. Each pixel result is emitted on a valid/ready stream towards the framebuffer/VGA colour-mapping stage.

Parameters:
BITWIDTH, 12, total signed fixed-point width of z and c
FRAC, 9, fractional bits (1.0 = 2^FRAC); representable range [-2^(BITWIDTH-FRAC-1), +2^(BITWIDTH-FRAC-1))
CTRWIDTH, 8, iteration counter width
STEPWIDTH, 8, signed step width, sign-extended to BITWIDTH
WIDTH, 320, pixels per line
HEIGHT, 240, lines per frame

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  frame start request; honoured only in IDLE
abort  in  1  cancel frame; priority over everything except reset
mode  in  1  0 = Mandelbrot, 1 = Julia
max_iter  in  CTRWIDTH  iteration limit
cr_origin, ci_origin  in  BITWIDTH each  coordinate of pixel (0,0)
cr_step, ci_step  in  STEPWIDTH each  signed per-pixel / per-line increment
julia_cr, julia_ci  in  BITWIDTH each  constant c in Julia mode
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse when the last pixel is accepted
pix_valid  out  1  result valid
pix_ready  in  1  consumer accepts the result
pix_iter  out  CTRWIDTH  iteration count
pix_escaped  out  1  1 = escaped, 0 = hit max_iter
pix_x  out  clog2(WIDTH)  pixel column
pix_y  out  clog2(HEIGHT)  pixel line
pix_last  out  1  high with the final pixel of the frame

Behaviour:
- Reset: state IDLE; busy, done, pix_valid, pix_last, pix_escaped = 0; pix_iter, pix_x, pix_y = 0; internal registers cleared.
- All configuration inputs are latched on the start-accept cycle. Later changes have no effect until the next frame.
- States:
  - IDLE: start=1 -> INIT, busy=1, x=y=0, pr=cr_origin, pi=ci_origin.
  - INIT (1 cycle): Mandelbrot: z=0, c=(pr,pi). Julia: z=(pr,pi), c=(julia_cr,julia_ci). iter=0 -> ITER.
  - ITER (one iteration per cycle), conditions tested in order:
    (a) mag = (zr*zr + zi*zi) >>> FRAC, full precision; mag >= 4<<FRAC -> result iter, escaped=1.
    (b) iter == max_iter -> result iter, escaped=0.
    (c) otherwise nzr = ((zr*zr - zi*zi) >>> FRAC) + cr and nzi = ((2*zr*zi) >>> FRAC) + ci, both full precision. If either does not fit in signed BITWIDTH -> result iter+1, escaped=1. Else z<=(nzr,nzi), iter<=iter+1.
    Any result -> OUTPUT.
  - OUTPUT: pix_valid=1. pix_iter, pix_escaped, pix_x, pix_y and pix_last stay stable until pix_ready=1. On the handshake:
    - x==WIDTH-1 and y==HEIGHT-1: -> IDLE, done=1 for 1 cycle, busy=0.
    - x==WIDTH-1 otherwise: x=0, y+1, pr=cr_origin, pi=pi+sext(ci_step) -> INIT.
    - else: x+1, pr=pr+sext(cr_step) -> INIT.
- Handshake: pix_valid does not depend combinationally on pix_ready. pix_valid drops the cycle after the handshake.
- Cycle count: a pixel with result iter=n costs 1 (INIT) + n+1 (ITER) + >=1 (OUTPUT) cycles. Exception: an overflow exit costs n cycles in ITER.
- Coordinate accumulation wraps modulo 2^BITWIDTH; no saturation.
- max_iter=0: every pixel leaves ITER after one cycle. Result is iter=0 with escaped=0, unless (a) hits (only possible in Julia mode).
- abort=1 in any non-IDLE state: next cycle IDLE, busy=0, pix_valid=0, done not pulsed.
- abort and start in the same IDLE cycle: start ignored.
- start while busy: ignored.
- Reset mid-frame: immediate return to reset values.

Test Plan:
- Defaults BITWIDTH=12, FRAC=9; WIDTH=4, HEIGHT=2; Mandelbrot; cr_origin=-1024, cr_step=+512 (so cr = -2.0, -1.0, 0.0, 1.0); ci_origin=0, ci_step=0; max_iter=20; pix_ready=1. Required: pix_iter = 1,20,20,2; escaped = 1,0,0,1; both rows identical; pix_last only on (3,1); one done pulse; busy low afterwards.
- Same frame with pix_ready held 0 for 5 cycles on pixel (1,0) -> outputs stable throughout; exactly 8 handshakes; no duplicated or skipped coordinate.
- max_iter=0, Mandelbrot -> all 8 pixels iter=0, escaped=0; each pixel takes 3 cycles with ready=1.
- Julia mode, julia_c=(0,0), pixels z0=(1024,0) and (512,0), max_iter=5. Required: z0=2.0 gives iter=0, escaped=1; z0=1.0 gives iter=5, escaped=0.
- Overflow: Mandelbrot, c=(1536,0), i.e. 3.0. z1=3.0, mag 9 >= 4 -> iter=1, escaped=1. With c=(2047,2047) -> escape via (a) at iter=1, no wrap artefact.
- abort asserted mid-ITER on pixel (2,0) -> IDLE next cycle, no done, pix_valid=0. A new start then restarts at (0,0) using the newly latched configuration.

Source files
------------

// File: rtl/mandelbrot_frame_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mandelbrot_frame_engine                                    |
// | Description : Raster-scanning Mandelbrot/Julia pixel engine. Performs    |
// |               one z <- z^2 + c iteration per clock on a signed fixed-    |
// |               point datapath and streams one result per pixel over a     |
// |               valid/ready interface.                                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mandelbrot_frame_engine #(
  parameter  int BITWIDTH  = 12,
  parameter  int FRAC      = 9,
  parameter  int CTRWIDTH  = 8,
  parameter  int STEPWIDTH = 8,
  parameter  int WIDTH     = 320,
  parameter  int HEIGHT    = 240,
  localparam int c_XW      = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int c_YW      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic                        i_mode,
  input  logic [CTRWIDTH-1:0]         i_max_iter,
  input  logic signed [BITWIDTH-1:0]  i_cr_origin,
  input  logic signed [BITWIDTH-1:0]  i_ci_origin,
  input  logic signed [STEPWIDTH-1:0] i_cr_step,
  input  logic signed [STEPWIDTH-1:0] i_ci_step,
  input  logic signed [BITWIDTH-1:0]  i_julia_cr,
  input  logic signed [BITWIDTH-1:0]  i_julia_ci,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_pix_valid,
  input  logic                        i_pix_ready,
  output logic [CTRWIDTH-1:0]         o_pix_iter,
  output logic                        o_pix_escaped,
  output logic [c_XW-1:0]             o_pix_x,
  output logic [c_YW-1:0]             o_pix_y,
  output logic                        o_pix_last
);

  // Internal arithmetic width: holds squares, their sum and 2*zr*zi exactly,
  // so neither the escape test nor the overflow test can be fooled by a wrap.
  localparam int c_PW = 2 * BITWIDTH + 2;
  localparam logic signed [c_PW-1:0] c_ESC_MAG = c_PW'(4 << FRAC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INIT   = 2'd1,
    S_ITER   = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t r_state;

  // Frame configuration captured when start is accepted
  logic                        r_mode;
  logic [CTRWIDTH-1:0]         r_max_iter;
  logic signed [BITWIDTH-1:0]  r_cr_origin;
  logic signed [STEPWIDTH-1:0] r_cr_step;
  logic signed [STEPWIDTH-1:0] r_ci_step;
  logic signed [BITWIDTH-1:0]  r_julia_cr;
  logic signed [BITWIDTH-1:0]  r_julia_ci;

  // Scan position and the complex coordinate of the current pixel
  logic [c_XW-1:0]             r_x;
  logic [c_YW-1:0]             r_y;
  logic signed [BITWIDTH-1:0]  r_pr;
  logic signed [BITWIDTH-1:0]  r_pi;

  // Iteration state
  logic signed [BITWIDTH-1:0]  r_zr;
  logic signed [BITWIDTH-1:0]  r_zi;
  logic signed [BITWIDTH-1:0]  r_cr;
  logic signed [BITWIDTH-1:0]  r_ci;
  logic [CTRWIDTH-1:0]         r_iter;

  // Registered outputs
  logic                        r_busy;
  logic                        r_done;
  logic                        r_pix_valid;
  logic [CTRWIDTH-1:0]         r_pix_iter;
  logic                        r_pix_escaped;
  logic                        r_pix_last;

  // Datapath wires
  logic signed [c_PW-1:0]      w_zr_ext;
  logic signed [c_PW-1:0]      w_zi_ext;
  logic signed [c_PW-1:0]      w_cr_ext;
  logic signed [c_PW-1:0]      w_ci_ext;
  logic signed [c_PW-1:0]      w_zr_sq;
  logic signed [c_PW-1:0]      w_zi_sq;
  logic signed [c_PW-1:0]      w_zrzi;
  logic signed [c_PW-1:0]      w_mag;
  logic signed [c_PW-1:0]      w_nzr;
  logic signed [c_PW-1:0]      w_nzi;
  logic                        w_mag_esc;
  logic                        w_nzr_fit;
  logic                        w_nzi_fit;
  logic [CTRWIDTH-1:0]         w_iter_inc;
  logic signed [BITWIDTH-1:0]  w_cr_step_ext;
  logic signed [BITWIDTH-1:0]  w_ci_step_ext;
  logic                        w_x_end;
  logic                        w_y_end;

  // Pixel result decision for the current ITER cycle
  logic                        w_res_hit;
  logic                        w_res_esc;
  logic [CTRWIDTH-1:0]         w_res_iter;

  assign w_zr_ext = c_PW'(r_zr);
  assign w_zi_ext = c_PW'(r_zi);
  assign w_cr_ext = c_PW'(r_cr);
  assign w_ci_ext = c_PW'(r_ci);

  assign w_zr_sq  = w_zr_ext * w_zr_ext;
  assign w_zi_sq  = w_zi_ext * w_zi_ext;
  assign w_zrzi   = w_zr_ext * w_zi_ext;

  assign w_mag    = (w_zr_sq + w_zi_sq) >>> FRAC;
  assign w_nzr    = ((w_zr_sq - w_zi_sq) >>> FRAC) + w_cr_ext;
  assign w_nzi    = ((w_zrzi <<< 1) >>> FRAC) + w_ci_ext;

  assign w_mag_esc = (w_mag >= c_ESC_MAG);

  // A value fits in BITWIDTH signed when every bit above the sign bit agrees
  assign w_nzr_fit = (&w_nzr[c_PW-1:BITWIDTH-1]) | ~(|w_nzr[c_PW-1:BITWIDTH-1]);
  assign w_nzi_fit = (&w_nzi[c_PW-1:BITWIDTH-1]) | ~(|w_nzi[c_PW-1:BITWIDTH-1]);

  assign w_iter_inc    = r_iter + CTRWIDTH'(1);
  assign w_cr_step_ext = BITWIDTH'(r_cr_step);
  assign w_ci_step_ext = BITWIDTH'(r_ci_step);

  assign w_x_end = (r_x == c_XW'(WIDTH - 1));
  assign w_y_end = (r_y == c_YW'(HEIGHT - 1));

  // Priority-ordered exit tests: escape, iteration limit, then overflow
  always_comb begin
    w_res_hit  = 1'b1;
    w_res_esc  = 1'b1;
    w_res_iter = r_iter;
    if (w_mag_esc) begin
      w_res_esc = 1'b1;
    end else if (r_iter == r_max_iter) begin
      w_res_esc = 1'b0;
    end else if (!(w_nzr_fit && w_nzi_fit)) begin
      w_res_iter = w_iter_inc;
    end else begin
      w_res_hit = 1'b0;
    end
  end

  // Frame control FSM, iteration datapath and registered stream outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_mode        <= 1'b0;
      r_max_iter    <= '0;
      r_cr_origin   <= '0;
      r_cr_step     <= '0;
      r_ci_step     <= '0;
      r_julia_cr    <= '0;
      r_julia_ci    <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_pr          <= '0;
      r_pi          <= '0;
      r_zr          <= '0;
      r_zi          <= '0;
      r_cr          <= '0;
      r_ci          <= '0;
      r_iter        <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pix_valid   <= 1'b0;
      r_pix_iter    <= '0;
      r_pix_escaped <= 1'b0;
      r_pix_last    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        // Abort wins over start, so an IDLE abort+start leaves us idle
        r_state     <= S_IDLE;
        r_busy      <= 1'b0;
        r_pix_valid <= 1'b0;
        r_pix_last  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_mode      <= i_mode;
              r_max_iter  <= i_max_iter;
              r_cr_origin <= i_cr_origin;
              r_cr_step   <= i_cr_step;
              r_ci_step   <= i_ci_step;
              r_julia_cr  <= i_julia_cr;
              r_julia_ci  <= i_julia_ci;
              r_x         <= '0;
              r_y         <= '0;
              r_pr        <= i_cr_origin;
              r_pi        <= i_ci_origin;
              r_busy      <= 1'b1;
              r_state     <= S_INIT;
            end
          end

          S_INIT: begin
            if (r_mode) begin
              r_zr <= r_pr;
              r_zi <= r_pi;
              r_cr <= r_julia_cr;
              r_ci <= r_julia_ci;
            end else begin
              r_zr <= '0;
              r_zi <= '0;
              r_cr <= r_pr;
              r_ci <= r_pi;
            end
            r_iter  <= '0;
            r_state <= S_ITER;
          end

          S_ITER: begin
            if (w_res_hit) begin
              r_pix_iter    <= w_res_iter;
              r_pix_escaped <= w_res_esc;
              r_pix_last    <= w_x_end && w_y_end;
              r_pix_valid   <= 1'b1;
              r_state       <= S_OUTPUT;
            end else begin
              r_zr   <= w_nzr[BITWIDTH-1:0];
              r_zi   <= w_nzi[BITWIDTH-1:0];
              r_iter <= w_iter_inc;
            end
          end

          S_OUTPUT: begin
            // pix_valid is held high for the whole state, so ready alone
            // marks the handshake
            if (i_pix_ready) begin
              r_pix_valid <= 1'b0;
              r_pix_last  <= 1'b0;
              if (w_x_end && w_y_end) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else if (w_x_end) begin
                r_x     <= '0;
                r_y     <= r_y + c_YW'(1);
                r_pr    <= r_cr_origin;
                r_pi    <= r_pi + w_ci_step_ext;
                r_state <= S_INIT;
              end else begin
                r_x     <= r_x + c_XW'(1);
                r_pr    <= r_pr + w_cr_step_ext;
                r_state <= S_INIT;
              end
            end
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_pix_valid   = r_pix_valid;
  assign o_pix_iter    = r_pix_iter;
  assign o_pix_escaped = r_pix_escaped;
  assign o_pix_x       = r_x;
  assign o_pix_y       = r_y;
  assign o_pix_last    = r_pix_last;

endmodule
`default_nettype wire

// File: tb/tb_mandelbrot_frame_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mandelbrot_frame_engine                                 |
// | Description : Self-checking bench for mandelbrot_frame_engine on a 4x2   |
// |               frame, with a behavioural escape-time reference model.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mandelbrot_frame_engine;
  localparam int BW = 12;
  localparam int FR = 9;
  localparam int CW = 8;
  localparam int SW = 11;
  localparam int W  = 4;
  localparam int H  = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic start, abort, mode, pix_ready;
  logic [CW-1:0] max_iter;
  logic signed [BW-1:0] cr_origin, ci_origin, julia_cr, julia_ci;
  logic signed [SW-1:0] cr_step, ci_step;
  logic busy, done, pix_valid, pix_escaped, pix_last;
  logic [CW-1:0] pix_iter;
  logic [1:0] pix_x;
  logic [0:0] pix_y;

  int errors = 0;
  int checks = 0;

  // configuration the model believes was latched
  int m_mode, m_mi, m_cro, m_cio, m_crs, m_cis, m_jcr, m_jci;

  // results collected from one frame
  int q_it[$], q_esc[$], q_x[$], q_y[$], q_last[$], q_cyc[$];
  int n_done;
  bit tmo;
  bit stall_ok;

  mandelbrot_frame_engine #(
    .BITWIDTH(BW), .FRAC(FR), .CTRWIDTH(CW), .STEPWIDTH(SW), .WIDTH(W), .HEIGHT(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_mode(mode),
    .i_max_iter(max_iter), .i_cr_origin(cr_origin), .i_ci_origin(ci_origin),
    .i_cr_step(cr_step), .i_ci_step(ci_step), .i_julia_cr(julia_cr), .i_julia_ci(julia_ci),
    .o_busy(busy), .o_done(done), .o_pix_valid(pix_valid), .i_pix_ready(pix_ready),
    .o_pix_iter(pix_iter), .o_pix_escaped(pix_escaped), .o_pix_x(pix_x), .o_pix_y(pix_y),
    .o_pix_last(pix_last)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int wrapb(input longint v);
    logic signed [BW-1:0] t;
    t = BW'(v);
    return int'(t);
  endfunction

  // Escape-time reference: iterate the recurrence on plain integers
  function automatic void model(input int x, input int y, output int it, output int esc);
    longint pr, pi, zr, zi, cr, ci, mag, nzr, nzi, lim;
    lim = longint'(1) <<< (BW - 1);
    pr = wrapb(longint'(m_cro) + longint'(x) * m_crs);
    pi = wrapb(longint'(m_cio) + longint'(y) * m_cis);
    if (m_mode == 0) begin zr = 0; zi = 0; cr = pr; ci = pi; end
    else begin zr = pr; zi = pi; cr = m_jcr; ci = m_jci; end
    it = -1; esc = -1;
    for (int k = 0; k <= 300; k++) begin
      mag = (zr * zr + zi * zi) >>> FR;
      if (mag >= (longint'(4) <<< FR)) begin it = k; esc = 1; return; end
      if (k == m_mi) begin it = k; esc = 0; return; end
      nzr = ((zr * zr - zi * zi) >>> FR) + cr;
      nzi = ((2 * zr * zi) >>> FR) + ci;
      if (nzr < -lim || nzr > lim - 1 || nzi < -lim || nzi > lim - 1) begin
        it = k + 1; esc = 1; return;
      end
      zr = nzr; zi = nzi;
    end
  endfunction

  task automatic set_cfg(input int md, input int mi, input int cro, input int cio,
                         input int crs, input int cis, input int jcr, input int jci);
    mode = 1'(md); max_iter = CW'(mi);
    cr_origin = BW'(cro); ci_origin = BW'(cio);
    cr_step = SW'(crs); ci_step = SW'(cis);
    julia_cr = BW'(jcr); julia_ci = BW'(jci);
    m_mode = md; m_mi = mi; m_cro = cro; m_cio = cio;
    m_crs = crs; m_cis = cis; m_jcr = jcr; m_jci = jci;
  endtask

  // Starts a frame and records every handshake until done or budget expiry
  task automatic run_frame(input int stall_x, input int stall_y, input int stall_n,
                           input bit rnd_ready, input bit noise, input int budget);
    int cyc, left, h_it, h_esc, h_last;
    bit held;
    q_it.delete(); q_esc.delete(); q_x.delete(); q_y.delete(); q_last.delete(); q_cyc.delete();
    n_done = 0; tmo = 0; stall_ok = 1; cyc = 0; left = stall_n; held = 0;
    h_it = 0; h_esc = 0; h_last = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    if (noise) begin
      mode = 1'($urandom_range(0, 1)); max_iter = CW'($urandom);
      cr_origin = BW'($urandom); ci_origin = BW'($urandom);
      cr_step = SW'($urandom); ci_step = SW'($urandom);
      julia_cr = BW'($urandom); julia_ci = BW'($urandom);
    end
    forever begin
      if (done) begin n_done++; break; end
      if (cyc >= budget) begin tmo = 1; break; end
      if (pix_valid) begin
        if (int'(pix_x) == stall_x && int'(pix_y) == stall_y && left > 0) begin
          pix_ready = 1'b0;
          if (!held) begin
            held = 1; h_it = int'(pix_iter); h_esc = int'(pix_escaped); h_last = int'(pix_last);
          end else if (int'(pix_iter) != h_it || int'(pix_escaped) != h_esc ||
                       int'(pix_last) != h_last) begin
            stall_ok = 0;
          end
          left--;
        end else begin
          pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
          if (held && (int'(pix_iter) != h_it || int'(pix_escaped) != h_esc ||
                       int'(pix_x) != stall_x || int'(pix_y) != stall_y)) stall_ok = 0;
          if (pix_ready) begin
            q_it.push_back(int'(pix_iter)); q_esc.push_back(int'(pix_escaped));
            q_x.push_back(int'(pix_x)); q_y.push_back(int'(pix_y));
            q_last.push_back(int'(pix_last)); q_cyc.push_back(cyc);
            held = 0;
          end
        end
      end else begin
        pix_ready = 1'($urandom_range(0, 1));
      end
      if (noise) start = 1'($urandom_range(0, 1));
      @(negedge clk); cyc++;
    end
    start = 1'b0; pix_ready = 1'b1;
    repeat (3) begin @(negedge clk); if (done) n_done++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; abort = 0; pix_ready = 1;
    set_cfg(0, 20, -1024, 0, 512, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pix_valid); end
    checks++; if (pix_last !== 1'b0 || pix_escaped !== 1'b0) begin
      errors++; $display("FAIL reset_flags: last=%b esc=%b want 0 0", pix_last, pix_escaped); end
    checks++; if (pix_iter !== 8'd0 || pix_x !== 2'd0 || pix_y !== 1'd0) begin
      errors++; $display("FAIL reset_data: iter=%0d x=%0d y=%0d want 0 0 0", pix_iter, pix_x, pix_y); end
  endtask

  task automatic test_basic();
    int exp_it[4];
    int exp_esc[4];
    exp_it = '{1, 20, 20, 2};
    exp_esc = '{1, 0, 0, 1};
    set_cfg(0, 20, -1024, 0, 512, 0, 0, 0);
    run_frame(-1, -1, 0, 0, 0, 500);
    checks++; if (tmo) begin errors++; $display("FAIL basic_timeout: got timeout want done"); end
    checks++; if (q_x.size() != 8) begin errors++; $display("FAIL basic_count: got %0d want 8", q_x.size()); end
    foreach (q_x[i]) begin
      checks++;
      if (q_it[i] != exp_it[i % 4] || q_esc[i] != exp_esc[i % 4] || q_x[i] != i % 4 ||
          q_y[i] != i / 4 || q_last[i] != int'(i == 7)) begin
        errors++;
        $display("FAIL basic_pix%0d: got it=%0d esc=%0d x=%0d y=%0d last=%0d want it=%0d esc=%0d x=%0d y=%0d last=%0d",
                 i, q_it[i], q_esc[i], q_x[i], q_y[i], q_last[i], exp_it[i % 4], exp_esc[i % 4],
                 i % 4, i / 4, int'(i == 7));
      end
    end
    checks++; if (n_done != 1) begin errors++; $display("FAIL basic_done: got %0d pulses want 1", n_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_stall();
    int exp_it[4];
    exp_it = '{1, 20, 20, 2};
    set_cfg(0, 20, -1024, 0, 512, 0, 0, 0);
    run_frame(1, 0, 5, 0, 0, 500);
    checks++; if (!stall_ok) begin errors++; $display("FAIL stall_stable: got changed outputs want stable"); end
    checks++; if (q_x.size() != 8 || tmo) begin
      errors++; $display("FAIL stall_count: got %0d handshakes tmo=%0d want 8 0", q_x.size(), tmo); end
    foreach (q_x[i]) begin
      checks++;
      if (q_x[i] != i % 4 || q_y[i] != i / 4 || q_it[i] != exp_it[i % 4]) begin
        errors++;
        $display("FAIL stall_pix%0d: got x=%0d y=%0d it=%0d want x=%0d y=%0d it=%0d",
                 i, q_x[i], q_y[i], q_it[i], i % 4, i / 4, exp_it[i % 4]);
      end
    end
    checks++; if (n_done != 1) begin errors++; $display("FAIL stall_done: got %0d want 1", n_done); end
  endtask

  task automatic test_maxiter0();
    set_cfg(0, 0, -1024, 0, 512, 0, 0, 0);
    run_frame(-1, -1, 0, 0, 0, 200);
    checks++; if (q_x.size() != 8 || tmo) begin
      errors++; $display("FAIL mi0_count: got %0d tmo=%0d want 8 0", q_x.size(), tmo); end
    foreach (q_x[i]) begin
      checks++;
      if (q_it[i] != 0 || q_esc[i] != 0) begin
        errors++; $display("FAIL mi0_pix%0d: got it=%0d esc=%0d want 0 0", i, q_it[i], q_esc[i]);
      end
      if (i > 0) begin
        checks++;
        if (q_cyc[i] - q_cyc[i-1] != 3) begin
          errors++; $display("FAIL mi0_cycles%0d: got %0d want 3", i, q_cyc[i] - q_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_julia();
    int it, esc;
    set_cfg(1, 5, 1024, 0, -512, 0, 0, 0);
    run_frame(-1, -1, 0, 0, 0, 500);
    checks++; if (q_x.size() != 8 || tmo) begin
      errors++; $display("FAIL julia_count: got %0d tmo=%0d want 8 0", q_x.size(), tmo); end
    foreach (q_x[i]) begin
      if (q_x[i] == 0) begin
        checks++;
        if (q_it[i] != 0 || q_esc[i] != 1) begin
          errors++; $display("FAIL julia_z2: got it=%0d esc=%0d want 0 1", q_it[i], q_esc[i]); end
      end else if (q_x[i] == 1) begin
        checks++;
        if (q_it[i] != 5 || q_esc[i] != 0) begin
          errors++; $display("FAIL julia_z1: got it=%0d esc=%0d want 5 0", q_it[i], q_esc[i]); end
      end else begin
        model(q_x[i], q_y[i], it, esc);
        checks++;
        if (q_it[i] != it || q_esc[i] != esc) begin
          errors++; $display("FAIL julia_pix%0d: got it=%0d esc=%0d want %0d %0d", i, q_it[i], q_esc[i], it, esc); end
      end
    end
  endtask

  task automatic test_overflow();
    set_cfg(0, 20, 1536, 0, 0, 0, 0, 0);
    run_frame(-1, -1, 0, 0, 0, 200);
    checks++; if (q_x.size() != 8 || tmo) begin
      errors++; $display("FAIL ovf3_count: got %0d tmo=%0d want 8 0", q_x.size(), tmo); end
    foreach (q_x[i]) begin
      checks++;
      if (q_it[i] != 1 || q_esc[i] != 1) begin
        errors++; $display("FAIL ovf3_pix%0d: got it=%0d esc=%0d want 1 1", i, q_it[i], q_esc[i]); end
    end
    set_cfg(0, 20, 2047, 2047, 0, 0, 0, 0);
    run_frame(-1, -1, 0, 0, 0, 200);
    checks++; if (q_x.size() != 8 || tmo) begin
      errors++; $display("FAIL ovfmax_count: got %0d tmo=%0d want 8 0", q_x.size(), tmo); end
    foreach (q_x[i]) begin
      checks++;
      if (q_it[i] != 1 || q_esc[i] != 1) begin
        errors++; $display("FAIL ovfmax_pix%0d: got it=%0d esc=%0d want 1 1", i, q_it[i], q_esc[i]); end
    end
  endtask

  task automatic test_abort();
    int cyc, it, esc;
    bit bad;
    set_cfg(0, 20, -1024, 0, 512, 0, 0, 0);
    pix_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (cyc < 300 && !(pix_x == 2'd2 && !pix_valid)) begin @(negedge clk); cyc++; end
    checks++; if (cyc >= 300) begin errors++; $display("FAIL abort_reach: got timeout want pixel (2,0)"); end
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++; if (busy !== 1'b0 || pix_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got busy=%b valid=%b done=%b want 0 0 0", busy, pix_valid, done); end
    bad = 0;
    repeat (6) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) bad = 1; end
    checks++; if (bad) begin errors++; $display("FAIL abort_quiet: got activity after abort want none"); end
    set_cfg(0, 7, -600, -300, 250, 600, 0, 0);
    run_frame(-1, -1, 0, 0, 0, 500);
    checks++; if (q_x.size() != 8 || tmo) begin
      errors++; $display("FAIL restart_count: got %0d tmo=%0d want 8 0", q_x.size(), tmo); end
    checks++; if (q_x.size() == 0 || q_x[0] != 0 || q_y[0] != 0) begin
      errors++; $display("FAIL restart_origin: got first pixel not at (0,0) want (0,0)"); end
    foreach (q_x[i]) begin
      model(i % 4, i / 4, it, esc);
      checks++;
      if (q_it[i] != it || q_esc[i] != esc || q_x[i] != i % 4 || q_y[i] != i / 4) begin
        errors++; $display("FAIL restart_pix%0d: got it=%0d esc=%0d x=%0d y=%0d want %0d %0d %0d %0d",
                           i, q_it[i], q_esc[i], q_x[i], q_y[i], it, esc, i % 4, i / 4); end
    end
  endtask

  task automatic test_start_abort_idle();
    bit bad;
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    bad = 0;
    repeat (4) begin if (busy !== 1'b0 || pix_valid !== 1'b0) bad = 1; @(negedge clk); end
    checks++; if (bad) begin errors++; $display("FAIL start_abort: got frame started want idle"); end
  endtask

  task automatic test_random();
    int it, esc;
    for (int f = 0; f < 6; f++) begin
      set_cfg($urandom_range(0, 1), $urandom_range(0, 30),
              int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
              int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024,
              int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024);
      run_frame(-1, -1, 0, 1, 1, 3000);
      checks++; if (q_x.size() != 8 || tmo || n_done != 1) begin
        errors++; $display("FAIL rand%0d_frame: got %0d pix tmo=%0d done=%0d want 8 0 1", f, q_x.size(), tmo, n_done); end
      foreach (q_x[i]) begin
        model(i % 4, i / 4, it, esc);
        checks++;
        if (q_it[i] != it || q_esc[i] != esc || q_x[i] != i % 4 || q_y[i] != i / 4 ||
            q_last[i] != int'(i == 7)) begin
          errors++; $display("FAIL rand%0d_pix%0d: got it=%0d esc=%0d x=%0d y=%0d want %0d %0d %0d %0d",
                             f, i, q_it[i], q_esc[i], q_x[i], q_y[i], it, esc, i % 4, i / 4); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    set_cfg(0, 20, -1024, 0, 512, 0, 0, 0);
    pix_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || pix_valid !== 1'b0 || pix_x !== 2'd0 || pix_iter !== 8'd0) begin
      errors++; $display("FAIL rst_mid: got busy=%b valid=%b x=%0d iter=%0d want 0 0 0 0", busy, pix_valid, pix_x, pix_iter); end
    @(negedge clk); rst_n = 1'b1;
    run_frame(-1, -1, 0, 0, 0, 500);
    checks++; if (q_x.size() != 8 || tmo) begin
      errors++; $display("FAIL rst_mid_after: got %0d pix tmo=%0d want 8 0", q_x.size(), tmo); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_maxiter0();
    test_julia();
    test_overflow();
    test_abort();
    test_start_abort_idle();
    test_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
